ysyx_23060180_mem_responder: RTL and testbench
==============================================

Name: ysyx_23060180_mem_responder

Overview:
- Word-addressed memory slave at the far end of the core's memory interface.
- Accepts one read or write request at a time, holds it for a programmable latency, then returns a single-cycle response with data or an error flag.
- Backs the core's fetch and load/store path in simulation and in the SoC-less build.
- Internal storage is an inferred RAM array.

Parameters:
- BASE, 32'h80000000, byte address mapped to word 0.
- DEPTH, 16384, number of 32-bit words; power of two.
- LATENCY, 1, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rstn_in  input  1  asynchronous, active-low reset.
- mem_rd  input  1  read request.
- mem_wr  input  1  write request.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte enables; bit i covers wdata[8i+7:8i].
- mem_ready  output  1  responder can accept a request this cycle.
- mem_rvalid  output  1  one-cycle response strobe.
- mem_rdata  output  32  read data; valid when mem_rvalid is high.
- mem_err  output  1  response error; valid when mem_rvalid is high.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rstn_in).
- Reset values: state=IDLE, mem_ready=1, mem_rvalid=0, mem_rdata=0, mem_err=0, counter=0. The RAM array is not reset.
- Acceptance: a request is accepted on the rising edge where mem_ready=1 and (mem_rd|mem_wr)=1. On acceptance, latch op, addr, wdata and wstrb. Requests are not queued, so inputs are don't-care while mem_ready=0.
- State machine (IDLE, WAIT, RESP):
  - IDLE: mem_ready=1. On accept, go to RESP if LATENCY==1; otherwise go to WAIT with cnt=LATENCY-2.
  - WAIT: mem_ready=0. Decrement cnt; when cnt==0, go to RESP.
  - RESP: mem_ready=0, mem_rvalid=1 for exactly one cycle, then go to IDLE.
- Latency: mem_rvalid rises LATENCY cycles after the accepting edge. Back-to-back throughput is one request per LATENCY+1 cycles.
- Decode: err when any of the following holds:
  - addr < BASE
  - addr >= BASE+4*DEPTH (compute in 33 bits, no wrap)
  - addr[1:0] != 0
  - mem_rd and mem_wr both high
- Index is (addr-BASE)>>2, width log2(DEPTH).
- Read: mem_rdata is registered on the edge entering RESP from RAM[index], or 0 when err. It holds its value until the next response.
- Write: on the edge entering RESP, write the bytes of RAM[index] whose strobe is set; skip the write when err.
  - A write response returns mem_rdata=0.
  - wstrb=0 is a legal no-op that still acknowledges.
- Read-after-write: a read accepted after a write's response returns the new data.
- mem_err is registered alongside mem_rdata and cleared when the responder leaves RESP.
- Reset mid-operation: abort to IDLE. An in-flight write is dropped if rstn_in falls before the RESP entry edge, and no response is issued.

Decomposition:
- Shared package ysyx_23060180_mem_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - MEM_BASE_DEFAULT = 32'h80000000
  - op enum {OP_RD, OP_WR}
- One natural sub-module, ysyx_23060180_sram_bwe: a single-port RAM with synchronous write, per-byte write enables and a combinational read index. It keeps the array inferable and swappable for a macro.
- Decode, counter and FSM stay in the top module.

Test Plan:
- Reset, then preload RAM[0]=32'h00100093 through the backdoor; read 0x80000000 with LATENCY=1 -> mem_rvalid one cycle after accept, rdata=32'h00100093, err=0, mem_ready=0 for exactly 1 cycle.
- LATENCY=3: write 0x80000010 with wdata=32'hDEADBEEF and wstrb=4'b1111, then read the same address -> each rvalid arrives 3 cycles after accept; the read returns 32'hDEADBEEF.
- Byte strobes: starting from RAM[1]=32'h11223344, write 32'hAABBCCDD to 0x80000004 with wstrb=4'b0101, then read -> 32'h11BB33DD.
- Errors:
  - read 0x7FFFFFFC -> err=1, rdata=0
  - read 0x80000002 -> err=1
  - read BASE+4*DEPTH -> err=1
  - write to an out-of-range address -> err=1 and the RAM is unchanged
  - rd and wr both high -> err=1
- Reset mid-op: LATENCY=4, accept a write of 32'h12345678 to 0x80000020, pulse rstn_in low during WAIT -> no rvalid, outputs return to reset values, and a later read returns the old contents.
- Back-to-back: hold mem_rd high continuously over addresses 0x80000000..0x8000000C with LATENCY=2 -> 4 responses, one every 3 cycles, in order, with no duplicate or lost response.

Source files
------------

// File: rtl/ysyx_23060180_mem_pkg.sv
// Shared types and defaults for the word-addressed memory responder.
package ysyx_23060180_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef enum logic {OP_RD, OP_WR} op_e;

    localparam logic [31:0] MEM_BASE_DEFAULT = 32'h80000000;

endpackage

// File: rtl/ysyx_23060180_sram_bwe.sv
// Single-port RAM: synchronous byte-enabled write, combinational read.
// Kept as its own module so the array can be replaced by a macro.
module ysyx_23060180_sram_bwe #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ysyx_23060180_mem_responder.sv
// Memory slave: accepts one request, waits LATENCY cycles, then returns a
// one-cycle response carrying read data or a decode error.
module ysyx_23060180_mem_responder
    import ysyx_23060180_mem_pkg::*;
#(
    parameter logic [31:0] BASE    = MEM_BASE_DEFAULT,
    parameter int          DEPTH   = 16384,
    parameter int          LATENCY = 1
) (
    input  logic        clk,
    input  logic        rstn_in,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
    localparam logic [32:0] ADDR_END = {1'b0, BASE} + (33'(DEPTH) << 2);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    op_e         op_q, op_d;
    logic        both_q, both_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        ready_q, ready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept, go_resp, idle;
    logic        cur_wr, cur_both, dec_err, ram_we;
    logic [31:0] cur_addr, cur_wdata, ram_rdata, rsp_rdata;
    logic [3:0]  cur_wstrb;
    logic [AW-1:0] ram_idx;

    assign idle    = (state_q == IDLE);
    assign accept  = ready_q & (mem_rd | mem_wr);
    assign go_resp = (idle && accept && LATENCY == 1) || (state_q == WAIT && cnt_q == 4'd0);

    // With LATENCY==1 the accepting edge is also the RESP entry edge, so the
    // live inputs must feed decode and RAM directly while idle.
    assign cur_addr  = idle ? mem_addr            : addr_q;
    assign cur_wdata = idle ? mem_wdata           : wdata_q;
    assign cur_wstrb = idle ? mem_wstrb           : wstrb_q;
    assign cur_wr    = idle ? mem_wr              : (op_q == OP_WR);
    assign cur_both  = idle ? (mem_rd & mem_wr)   : both_q;

    assign dec_err = (cur_addr < BASE) || ({1'b0, cur_addr} >= ADDR_END) ||
                     (cur_addr[1:0] != 2'b00) || cur_both;
    assign ram_idx   = cur_addr[AW+1:2] - BASE[AW+1:2];
    assign ram_we    = go_resp & cur_wr & ~dec_err;
    assign rsp_rdata = (dec_err || cur_wr) ? 32'h0 : ram_rdata;

    ysyx_23060180_sram_bwe #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (cur_wstrb),
        .idx   (ram_idx),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        both_d   = both_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        ready_d  = ready_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (accept) begin
                op_d    = mem_wr ? OP_WR : OP_RD;
                both_d  = mem_rd & mem_wr;
                addr_d  = mem_addr;
                wdata_d = mem_wdata;
                wstrb_d = mem_wstrb;
                ready_d = 1'b0;
                if (go_resp) state_d = RESP;
                else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: if (go_resp) state_d = RESP;
                  else cnt_d = cnt_q - 4'd1;
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (go_resp) begin
            rvalid_d = 1'b1;
            rdata_d  = rsp_rdata;
            err_d    = dec_err;
        end
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            op_q     <= OP_RD;
            both_q   <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'h0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            both_q   <= both_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign mem_ready  = ready_q;
    assign mem_rvalid = rvalid_q;
    assign mem_rdata  = rdata_q;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_ysyx_23060180_mem_responder.sv
// Bench: four responders with LATENCY 1..4 on shared address/data inputs;
// expected responses are queued at issue and popped when rvalid appears.
module tb_ysyx_23060180_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [3:0]  rd_v, wr_v;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic [3:0]  ready, rvalid, err;
    logic [3:0][31:0] rdata;

    int   checks;
    int   failures;
    exp_t sb[$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ysyx_23060180_mem_responder #(
            .BASE    (32'h80000000),
            .DEPTH   (16384),
            .LATENCY (g + 1)
        ) u_dut (
            .clk        (clk),
            .rstn_in    (rstn),
            .mem_rd     (rd_v[g]),
            .mem_wr     (wr_v[g]),
            .mem_addr   (addr),
            .mem_wdata  (wdata),
            .mem_wstrb  (wstrb),
            .mem_ready  (ready[g]),
            .mem_rvalid (rvalid[g]),
            .mem_rdata  (rdata[g]),
            .mem_err    (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input int inst, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        exp_t e;
        int   n;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        @(negedge clk);
        check({tag, ":ready_idle"}, 32'(ready[inst]), 32'd1);
        rd_v[inst] = rd;
        wr_v[inst] = wr;
        addr  = a;
        wdata = wd;
        wstrb = ws;
        @(posedge clk);
        #1;
        rd_v = 4'h0;
        wr_v = 4'h0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rvalid[inst]) break;
            check({tag, ":ready_busy"}, 32'(ready[inst]), 32'd0);
        end
        check({tag, ":latency"}, 32'(n), 32'(inst + 1));
        e = sb.pop_front();
        check({tag, ":rdata"}, rdata[inst], e.rdata);
        check({tag, ":err"}, 32'(err[inst]), 32'(e.err));
        @(negedge clk);
        check({tag, ":rvalid_drop"}, 32'(rvalid[inst]), 32'd0);
        check({tag, ":ready_back"}, 32'(ready[inst]), 32'd1);
        check({tag, ":err_clr"}, 32'(err[inst]), 32'd0);
    endtask

    initial begin
        int   cyc, last, got, sent;
        exp_t e;
        checks = 0;
        failures = 0;
        rstn  = 1'b0;
        rd_v  = 4'h0;
        wr_v  = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        wstrb = 4'h0;
        repeat (3) @(negedge clk);
        check("rst:ready", 32'(ready), 32'hF);
        check("rst:rvalid", 32'(rvalid), 32'h0);
        check("rst:err", 32'(err), 32'h0);
        for (int i = 0; i < 4; i++) check("rst:rdata", rdata[i], 32'h0);
        rstn = 1'b1;

        // LATENCY=1 basic read
        do_req(0, 0, 1, 32'h80000000, 32'h00100093, 4'hF, 32'h0, 0, "l1_pre");
        do_req(0, 1, 0, 32'h80000000, 32'h0, 4'h0, 32'h00100093, 0, "l1_rd");

        // LATENCY=3 write then read-after-write
        do_req(2, 0, 1, 32'h80000010, 32'hDEADBEEF, 4'hF, 32'h0, 0, "l3_wr");
        do_req(2, 1, 0, 32'h80000010, 32'h0, 4'h0, 32'hDEADBEEF, 0, "l3_rd");

        // byte strobes and zero-strobe no-op
        do_req(0, 0, 1, 32'h80000004, 32'h11223344, 4'hF, 32'h0, 0, "bs_pre");
        do_req(0, 0, 1, 32'h80000004, 32'hAABBCCDD, 4'b0101, 32'h0, 0, "bs_wr");
        do_req(0, 1, 0, 32'h80000004, 32'h0, 4'h0, 32'h11BB33DD, 0, "bs_rd");
        do_req(0, 0, 1, 32'h80000004, 32'hFFFFFFFF, 4'h0, 32'h0, 0, "ws0_wr");
        do_req(0, 1, 0, 32'h80000004, 32'h0, 4'h0, 32'h11BB33DD, 0, "ws0_rd");

        // decode errors and the last legal word
        do_req(0, 1, 0, 32'h7FFFFFFC, 32'h0, 4'h0, 32'h0, 1, "e_below");
        do_req(0, 1, 0, 32'h80000002, 32'h0, 4'h0, 32'h0, 1, "e_misal");
        do_req(0, 1, 0, 32'h80010000, 32'h0, 4'h0, 32'h0, 1, "e_end");
        do_req(0, 0, 1, 32'h80010000, 32'h55555555, 4'hF, 32'h0, 1, "e_wr_oor");
        do_req(0, 1, 0, 32'h80000000, 32'h0, 4'h0, 32'h00100093, 0, "e_unchg");
        do_req(0, 1, 1, 32'h80000000, 32'h66666666, 4'hF, 32'h0, 1, "e_both");
        do_req(0, 1, 0, 32'h80000000, 32'h0, 4'h0, 32'h00100093, 0, "e_both_unchg");
        do_req(0, 0, 1, 32'h8000FFFC, 32'h0BADF00D, 4'hF, 32'h0, 0, "last_wr");
        do_req(0, 1, 0, 32'h8000FFFC, 32'h0, 4'h0, 32'h0BADF00D, 0, "last_rd");

        // reset during WAIT drops the write and issues no response
        do_req(3, 0, 1, 32'h80000020, 32'hCAFEF00D, 4'hF, 32'h0, 0, "rm_pre");
        do_req(3, 1, 0, 32'h80000020, 32'h0, 4'h0, 32'hCAFEF00D, 0, "rm_prerd");
        @(negedge clk);
        wr_v[3] = 1'b1;
        addr  = 32'h80000020;
        wdata = 32'h12345678;
        wstrb = 4'hF;
        @(posedge clk);
        #1;
        wr_v = 4'h0;
        @(negedge clk);
        check("rm:busy", 32'(ready[3]), 32'd0);
        rstn = 1'b0;
        #1;
        check("rm:ready", 32'(ready[3]), 32'd1);
        check("rm:rvalid", 32'(rvalid[3]), 32'd0);
        check("rm:rdata", rdata[3], 32'h0);
        check("rm:err", 32'(err[3]), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rm:no_rvalid", 32'(rvalid), 32'h0);
        end
        do_req(3, 1, 0, 32'h80000020, 32'h0, 4'h0, 32'hCAFEF00D, 0, "rm_rd");

        // back-to-back reads on LATENCY=2 with mem_rd held high
        for (int i = 0; i < 4; i++)
            do_req(1, 0, 1, 32'h80000000 + 32'(4 * i), 32'hA5000000 + 32'(i), 4'hF, 32'h0, 0, "b2b_pre");
        for (int i = 0; i < 4; i++) begin
            e.rdata = 32'hA5000000 + 32'(i);
            e.err   = 1'b0;
            sb.push_back(e);
        end
        cyc = 0; last = 0; got = 0; sent = 0;
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (rvalid[1]) begin
                e = sb.pop_front();
                check("b2b:rdata", rdata[1], e.rdata);
                check("b2b:err", 32'(err[1]), 32'(e.err));
                if (got > 0) check("b2b:spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                got++;
            end
            if (ready[1]) begin
                if (sent < 4) begin
                    addr    = 32'h80000000 + 32'(4 * sent);
                    rd_v[1] = 1'b1;
                    sent++;
                end else rd_v[1] = 1'b0;
            end
        end
        rd_v = 4'h0;
        check("b2b:count", 32'(got), 32'd4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("b2b:no_extra", 32'(rvalid[1]), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
